// File: rtl/dcache_dma_pkg.sv
// Shared types and widths for the dcache DMA burst sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dcache_dma_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 18;
    localparam int SLOT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // RD encodes as 0 so that reset clears the grant history to "RD was last".
    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } gnt_t;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] len;
    } burst_cmd_t;

endpackage

// File: rtl/dcache_dma_rr_arb.sv
// Two-way round-robin arbiter between the fill (wr) and drain (rd) command ports.
// Latency: grant is combinational from the requests; history updates on take_i.
// Backpressure: a losing requester simply keeps its request up until granted.
module dcache_dma_rr_arb
    import dcache_dma_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_wr_i,
    input  logic req_rd_i,
    input  logic take_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    gnt_t last_q, last_d;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        gnt_wr_o = req_wr_i && (!req_rd_i || (last_q == GNT_RD));
        gnt_rd_o = req_rd_i && (!req_wr_i || (last_q == GNT_WR));
        last_d   = last_q;
        if (take_i) begin
            if (gnt_wr_o) begin
                last_d = GNT_WR;
            end else if (gnt_rd_o) begin
                last_d = GNT_RD;
            end
        end
    end

    // Grant history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_RD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dcache_dma_ctrl.sv
// Burst sequencer sharing the single-word dcache DMA port between a fill and a drain engine.
// Latency: fill word reaches dcache 1 cycle after its handshake; drain word appears 3 cycles after dma_re is decided.
// Backpressure: wr_dat_ready only in WRITE; drain issues a read only when the output register will be free.
module dcache_dma_ctrl
    import dcache_dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_cmd_valid,
    output logic              wr_cmd_ready,
    input  logic [SLOT_W-1:0] wr_cmd_slot,
    input  logic [ADDR_W-1:0] wr_cmd_addr,
    input  logic [ADDR_W-1:0] wr_cmd_len,
    input  logic              wr_dat_valid,
    output logic              wr_dat_ready,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_cmd_valid,
    output logic              rd_cmd_ready,
    input  logic [SLOT_W-1:0] rd_cmd_slot,
    input  logic [ADDR_W-1:0] rd_cmd_addr,
    input  logic [ADDR_W-1:0] rd_cmd_len,
    output logic              rd_dat_valid,
    input  logic              rd_dat_ready,
    output logic [DATA_W-1:0] rd_dat,
    output logic              rd_dat_last,
    output logic              wr_done,
    output logic              rd_done,
    output logic              busy,
    output logic [SLOT_W-1:0] dma_slot,
    output logic [ADDR_W-1:0] dma_addr,
    output logic              dma_we,
    output logic [DATA_W-1:0] dma_dat_w,
    output logic              dma_re,
    input  logic [DATA_W-1:0] dma_dat_r,
    input  logic              dma_dcache_read_complete
);

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] cur_slot_q, cur_slot_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic              is_rd_q, is_rd_d;
    logic              outstanding_q, outstanding_d;
    logic [DATA_W-1:0] rd_dat_q, rd_dat_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_last_q, rd_last_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_done_q, rd_done_d;
    logic              dma_we_q, dma_we_d;
    logic              dma_re_q, dma_re_d;
    logic [SLOT_W-1:0] dma_slot_q, dma_slot_d;
    logic [ADDR_W-1:0] dma_addr_q, dma_addr_d;
    logic [DATA_W-1:0] dma_dat_w_q, dma_dat_w_d;

    logic       gnt_wr, gnt_rd, take;
    burst_cmd_t cmd;

    dcache_dma_rr_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_wr_i (wr_cmd_valid),
        .req_rd_i (rd_cmd_valid),
        .take_i   (take),
        .gnt_wr_o (gnt_wr),
        .gnt_rd_o (gnt_rd)
    );

    // Command acceptance: only in IDLE, only for the granted side.
    always_comb begin
        take = (state_q == ST_IDLE) && (gnt_wr || gnt_rd);
        if (gnt_rd) begin
            cmd = '{slot: rd_cmd_slot, addr: rd_cmd_addr, len: rd_cmd_len};
        end else begin
            cmd = '{slot: wr_cmd_slot, addr: wr_cmd_addr, len: wr_cmd_len};
        end
    end

    assign wr_cmd_ready = (state_q == ST_IDLE) && gnt_wr;
    assign rd_cmd_ready = (state_q == ST_IDLE) && gnt_rd;
    assign wr_dat_ready = (state_q == ST_WRITE);
    assign busy         = (state_q != ST_IDLE);
    assign rd_dat_valid = rd_vld_q;
    assign rd_dat       = rd_dat_q;
    assign rd_dat_last  = rd_last_q;
    assign wr_done      = wr_done_q;
    assign rd_done      = rd_done_q;
    assign dma_we       = dma_we_q;
    assign dma_re       = dma_re_q;
    assign dma_slot     = dma_slot_q;
    assign dma_addr     = dma_addr_q;
    assign dma_dat_w    = dma_dat_w_q;

    // Next-state and datapath: strobes and done pulses default low every cycle.
    always_comb begin
        state_d       = state_q;
        cur_slot_d    = cur_slot_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        is_rd_d       = is_rd_q;
        outstanding_d = outstanding_q;
        rd_dat_d      = rd_dat_q;
        rd_vld_d      = rd_vld_q;
        rd_last_d     = rd_last_q;
        wr_done_d     = 1'b0;
        rd_done_d     = 1'b0;
        dma_we_d      = 1'b0;
        dma_re_d      = 1'b0;
        dma_slot_d    = dma_slot_q;
        dma_addr_d    = dma_addr_q;
        dma_dat_w_d   = dma_dat_w_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    cur_slot_d  = cmd.slot;
                    cur_addr_d  = cmd.addr;
                    remaining_d = cmd.len;
                    is_rd_d     = gnt_rd;
                    if (cmd.len == '0) begin
                        state_d = ST_DONE;
                    end else if (gnt_rd) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_dat_valid) begin
                    dma_we_d    = 1'b1;
                    dma_slot_d  = cur_slot_q;
                    dma_addr_d  = cur_addr_q;
                    dma_dat_w_d = wr_dat;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    if (remaining_q == ADDR_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (rd_vld_q && rd_dat_ready) begin
                    rd_vld_d  = 1'b0;
                    rd_last_d = 1'b0;
                    if (rd_last_q) begin
                        state_d = ST_DONE;
                    end
                end
                // remaining is decremented at issue, so zero here marks the final word.
                if (dma_dcache_read_complete && outstanding_q) begin
                    rd_dat_d      = dma_dat_r;
                    rd_vld_d      = 1'b1;
                    rd_last_d     = (remaining_q == '0);
                    outstanding_d = 1'b0;
                end
                // A read is issued only when the output register will have room for its data.
                if ((remaining_q != '0) && !outstanding_q && (!rd_vld_q || rd_dat_ready)) begin
                    dma_re_d      = 1'b1;
                    dma_slot_d    = cur_slot_q;
                    dma_addr_d    = cur_addr_q;
                    cur_addr_d    = cur_addr_q + ADDR_W'(1);
                    remaining_d   = remaining_q - ADDR_W'(1);
                    outstanding_d = 1'b1;
                end
            end
            ST_DONE: begin
                wr_done_d = !is_rd_q;
                rd_done_d = is_rd_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cur_slot_q    <= '0;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            is_rd_q       <= 1'b0;
            outstanding_q <= 1'b0;
            rd_dat_q      <= '0;
            rd_vld_q      <= 1'b0;
            rd_last_q     <= 1'b0;
            wr_done_q     <= 1'b0;
            rd_done_q     <= 1'b0;
            dma_we_q      <= 1'b0;
            dma_re_q      <= 1'b0;
            dma_slot_q    <= '0;
            dma_addr_q    <= '0;
            dma_dat_w_q   <= '0;
        end else begin
            state_q       <= state_d;
            cur_slot_q    <= cur_slot_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            is_rd_q       <= is_rd_d;
            outstanding_q <= outstanding_d;
            rd_dat_q      <= rd_dat_d;
            rd_vld_q      <= rd_vld_d;
            rd_last_q     <= rd_last_d;
            wr_done_q     <= wr_done_d;
            rd_done_q     <= rd_done_d;
            dma_we_q      <= dma_we_d;
            dma_re_q      <= dma_re_d;
            dma_slot_q    <= dma_slot_d;
            dma_addr_q    <= dma_addr_d;
            dma_dat_w_q   <= dma_dat_w_d;
        end
    end

endmodule

// File: tb/tb_dcache_dma_ctrl.sv
// Directed bench for dcache_dma_ctrl with a behavioural dcache attached to the DMA port.
// Latency: inputs change and outputs are sampled at the falling clock edge.
// Backpressure: drain stalls are driven on rd_dat_ready from the bench.
module tb_dcache_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_cmd_valid, wr_cmd_ready;
    logic [1:0]  wr_cmd_slot;
    logic [10:0] wr_cmd_addr, wr_cmd_len;
    logic        wr_dat_valid, wr_dat_ready;
    logic [17:0] wr_dat;
    logic        rd_cmd_valid, rd_cmd_ready;
    logic [1:0]  rd_cmd_slot;
    logic [10:0] rd_cmd_addr, rd_cmd_len;
    logic        rd_dat_valid, rd_dat_ready;
    logic [17:0] rd_dat;
    logic        rd_dat_last, wr_done, rd_done, busy;
    logic [1:0]  dma_slot;
    logic [10:0] dma_addr;
    logic        dma_we, dma_re;
    logic [17:0] dma_dat_w;
    logic [17:0] dma_dat_r = '0;
    logic        dma_dcache_read_complete = 1'b0;

    always #5 clk = ~clk;

    dcache_dma_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_slot(wr_cmd_slot), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
        .wr_dat_valid(wr_dat_valid), .wr_dat_ready(wr_dat_ready), .wr_dat(wr_dat),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_slot(rd_cmd_slot), .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
        .rd_dat_valid(rd_dat_valid), .rd_dat_ready(rd_dat_ready), .rd_dat(rd_dat),
        .rd_dat_last(rd_dat_last), .wr_done(wr_done), .rd_done(rd_done), .busy(busy),
        .dma_slot(dma_slot), .dma_addr(dma_addr), .dma_we(dma_we), .dma_dat_w(dma_dat_w),
        .dma_re(dma_re), .dma_dat_r(dma_dat_r),
        .dma_dcache_read_complete(dma_dcache_read_complete)
    );

    // Behavioural dcache: write on dma_we, read data and completion one cycle after dma_re.
    logic [17:0] mem [0:3][0:2047];
    always @(posedge clk) begin
        if (dma_we) mem[dma_slot][dma_addr] <= dma_dat_w;
        dma_dcache_read_complete <= dma_re;
        dma_dat_r <= mem[dma_slot][dma_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    logic [17:0] fill_words [0:7];
    logic [31:0] we_addr_q[$], we_dat_q[$], we_slot_q[$], we_t_q[$];
    logic [17:0] got_q[$];
    logic        got_last_q[$];
    int          we_cnt, re_cnt, done_cnt, done_at, first_re_t, first_vld_t;
    int          stall_re, stall_bad, stall_left, bad;
    bit          finished, in_stall;
    logic [17:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr_cmd(input logic [1:0] s, input logic [10:0] a, input logic [10:0] l);
        bit acc = 0;
        wr_cmd_slot = s; wr_cmd_addr = a; wr_cmd_len = l; wr_cmd_valid = 1'b1;
        #1;
        for (int t = 0; t < 20 && !acc; t++) begin
            if (wr_cmd_ready) acc = 1;
            cyc();
        end
        wr_cmd_valid = 1'b0;
        chk("wr_cmd_accept", acc, 1);
    endtask

    task automatic rd_cmd(input logic [1:0] s, input logic [10:0] a, input logic [10:0] l);
        bit acc = 0;
        rd_cmd_slot = s; rd_cmd_addr = a; rd_cmd_len = l; rd_cmd_valid = 1'b1;
        #1;
        for (int t = 0; t < 20 && !acc; t++) begin
            if (rd_cmd_ready) acc = 1;
            cyc();
        end
        rd_cmd_valid = 1'b0;
        chk("rd_cmd_accept", acc, 1);
    endtask

    // Starts at the first falling edge after a fill command was accepted.
    task automatic run_fill(input int len);
        int sent = 0;
        we_addr_q.delete(); we_dat_q.delete(); we_slot_q.delete(); we_t_q.delete();
        we_cnt = 0; re_cnt = 0; done_cnt = 0; done_at = 0; finished = 0;
        for (int t = 0; t < 60; t++) begin
            if (dma_we) begin
                we_cnt++;
                we_addr_q.push_back(32'(dma_addr));
                we_dat_q.push_back(32'(dma_dat_w));
                we_slot_q.push_back(32'(dma_slot));
                we_t_q.push_back(t);
            end
            if (dma_re) re_cnt++;
            if (wr_done) begin done_cnt++; done_at = t + 1; end
            if (rd_done) done_cnt += 100;
            if (done_cnt > 0 && !busy) begin finished = 1; break; end
            wr_dat_valid = (sent < len);
            if (sent < len) wr_dat = fill_words[sent];
            if (wr_dat_valid && wr_dat_ready) sent++;
            cyc();
        end
        wr_dat_valid = 1'b0;
        chk("fill_finish", finished, 1);
    endtask

    // Starts at the first falling edge after a drain command was accepted.
    task automatic run_drain(input int stall_at);
        got_q.delete(); got_last_q.delete();
        we_cnt = 0; re_cnt = 0; done_cnt = 0; done_at = 0; finished = 0;
        first_re_t = -1; first_vld_t = -1;
        stall_re = 0; stall_bad = 0; stall_left = 5; in_stall = 0;
        for (int t = 0; t < 80; t++) begin
            if (in_stall && dma_re) stall_re++;
            if (dma_re) begin re_cnt++; if (first_re_t < 0) first_re_t = t; end
            if (dma_we) we_cnt++;
            if (rd_done) begin done_cnt++; done_at = t + 1; end
            if (wr_done) done_cnt += 100;
            if (rd_dat_valid && first_vld_t < 0) first_vld_t = t;
            if (done_cnt > 0 && !busy) begin finished = 1; break; end
            in_stall = 0;
            if (rd_dat_valid && got_q.size() == stall_at && stall_left > 0) begin
                if (stall_left == 5) held = rd_dat;
                else if (rd_dat !== held) stall_bad++;
                in_stall = 1;
                stall_left--;
                rd_dat_ready = 1'b0;
            end else begin
                rd_dat_ready = 1'b1;
            end
            if (rd_dat_valid && rd_dat_ready) begin
                got_q.push_back(rd_dat);
                got_last_q.push_back(rd_dat_last);
            end
            cyc();
        end
        rd_dat_ready = 1'b0;
        chk("drain_finish", finished, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr_cmd_valid = 0; wr_cmd_slot = 0; wr_cmd_addr = 0; wr_cmd_len = 0;
        wr_dat_valid = 0; wr_dat = 0;
        rd_cmd_valid = 0; rd_cmd_slot = 0; rd_cmd_addr = 0; rd_cmd_len = 0;
        rd_dat_ready = 0;
        cyc(); cyc();
        chk("reset_ctrl", {busy, wr_cmd_ready, rd_cmd_ready, wr_dat_ready, rd_dat_valid,
                           rd_dat_last, wr_done, rd_done, dma_we, dma_re}, 0);
        chk("reset_data", {rd_dat, dma_addr}, 0);
        rst_n = 1'b1;
        cyc();

        // Tie from reset: WR wins; drain fields are junk while waiting.
        wr_cmd_slot = 2; wr_cmd_addr = 0; wr_cmd_len = 3; wr_cmd_valid = 1;
        rd_cmd_slot = 1; rd_cmd_addr = 55; rd_cmd_len = 9; rd_cmd_valid = 1;
        #1;
        chk("arb_tie_wr", {wr_cmd_ready, rd_cmd_ready}, 2'b10);
        cyc();
        wr_cmd_valid = 0;
        #1;
        chk("fill_state", {busy, rd_cmd_ready, wr_dat_ready}, 3'b101);
        fill_words[0] = 3423; fill_words[1] = 1337; fill_words[2] = 7;
        run_fill(3);
        chk("fill1_we_cnt", we_cnt, 3);
        chk("fill1_addrs", {we_addr_q[0][10:0], we_addr_q[1][10:0], we_addr_q[2][10:0]},
            {11'd0, 11'd1, 11'd2});
        chk("fill1_dat0", we_dat_q[0], 3423);
        chk("fill1_dat1", we_dat_q[1], 1337);
        chk("fill1_dat2", we_dat_q[2], 7);
        chk("fill1_slots", {we_slot_q[0][1:0], we_slot_q[1][1:0], we_slot_q[2][1:0]}, 6'b101010);
        chk("fill1_first_we_t", we_t_q[0], 1);
        chk("fill1_consecutive", we_t_q[2] - we_t_q[0], 2);
        chk("fill1_done_cnt", done_cnt, 1);
        chk("fill1_done_at", done_at, 5);
        chk("fill1_no_re", re_cnt, 0);

        // Both valid again: WR won last, so RD is served; drain fields now real.
        rd_cmd_slot = 2; rd_cmd_addr = 0; rd_cmd_len = 3;
        wr_cmd_slot = 0; wr_cmd_addr = 5; wr_cmd_len = 1; wr_cmd_valid = 1;
        #1;
        chk("arb_rr_rd", {wr_cmd_ready, rd_cmd_ready}, 2'b01);
        cyc();
        wr_cmd_valid = 0; rd_cmd_valid = 0;
        run_drain(-1);
        chk("drain1_w0", got_q[0], 3423);
        chk("drain1_w1", got_q[1], 1337);
        chk("drain1_w2", got_q[2], 7);
        chk("drain1_cnt", got_q.size(), 3);
        chk("drain1_last", {got_last_q[0], got_last_q[1], got_last_q[2]}, 3'b001);
        chk("drain1_re_cnt", re_cnt, 3);
        chk("drain1_first_re_t", first_re_t, 1);
        chk("drain1_first_vld_t", first_vld_t, 3);
        chk("drain1_done_cnt", done_cnt, 1);
        chk("drain1_done_at", done_at, 12);
        chk("drain1_no_we", we_cnt, 0);

        // Drain backpressure: five-cycle stall on the second word.
        for (int i = 0; i < 4; i++) fill_words[i] = 18'(500 + i);
        wr_cmd(1, 100, 4);
        run_fill(4);
        chk("fill2_we_cnt", we_cnt, 4);
        rd_cmd(1, 100, 4);
        run_drain(1);
        chk("bp_w0", got_q[0], 500);
        chk("bp_w1", got_q[1], 501);
        chk("bp_w2", got_q[2], 502);
        chk("bp_w3", got_q[3], 503);
        chk("bp_cnt", got_q.size(), 4);
        chk("bp_last", {got_last_q[0], got_last_q[1], got_last_q[2], got_last_q[3]}, 4'b0001);
        chk("bp_stall_len", stall_left, 0);
        chk("bp_stable", stall_bad, 0);
        chk("bp_no_re_in_stall", stall_re, 0);
        chk("bp_re_cnt", re_cnt, 4);
        chk("bp_done_cnt", done_cnt, 1);

        // Address wrap at the top of the slot.
        fill_words[0] = 10; fill_words[1] = 11; fill_words[2] = 12;
        wr_cmd(0, 2046, 3);
        run_fill(3);
        chk("wrap_addrs", {we_addr_q[0][10:0], we_addr_q[1][10:0], we_addr_q[2][10:0]},
            {11'd2046, 11'd2047, 11'd0});
        chk("wrap_slot", {we_slot_q[0][1:0], we_slot_q[2][1:0]}, 0);
        rd_cmd(0, 2046, 3);
        run_drain(-1);
        chk("wrap_rd", {got_q[0], got_q[1], got_q[2]}, {18'd10, 18'd11, 18'd12});

        // Zero-length bursts in both directions.
        wr_cmd(1, 7, 0);
        run_fill(0);
        chk("zero_wr_done_at", done_at, 2);
        chk("zero_wr_done_cnt", done_cnt, 1);
        chk("zero_wr_no_access", we_cnt + re_cnt, 0);
        rd_cmd(2, 9, 0);
        run_drain(-1);
        chk("zero_rd_done_at", done_at, 2);
        chk("zero_rd_done_cnt", done_cnt, 1);
        chk("zero_rd_no_access", we_cnt + re_cnt + got_q.size(), 0);

        // Reset part-way through a drain.
        for (int i = 0; i < 4; i++) fill_words[i] = 18'(900 + i);
        wr_cmd(3, 10, 4);
        run_fill(4);
        rd_cmd(3, 10, 4);
        got_q.delete();
        rd_dat_ready = 1'b1;
        for (int t = 0; t < 40 && got_q.size() < 1; t++) begin
            if (rd_dat_valid) got_q.push_back(rd_dat);
            cyc();
        end
        chk("rst_first_word", got_q[0], 900);
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl_zero", {busy, wr_cmd_ready, rd_cmd_ready, wr_dat_ready, rd_dat_valid,
                              rd_dat_last, wr_done, rd_done, dma_we, dma_re}, 0);
        chk("rst_data_zero", {rd_dat, dma_addr, dma_slot, dma_dat_w}, 0);
        rd_dat_ready = 1'b0;
        bad = 0;
        for (int t = 0; t < 3; t++) begin
            cyc();
            if (rd_done || busy) bad++;
        end
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            cyc();
            if (rd_done || wr_done || busy || dma_re || dma_we || rd_dat_valid) bad++;
        end
        chk("rst_abandon_quiet", bad, 0);
        rd_cmd(3, 10, 2);
        run_drain(-1);
        chk("post_rst_w0", got_q[0], 900);
        chk("post_rst_w1", got_q[1], 901);
        chk("post_rst_last", {got_last_q[0], got_last_q[1]}, 2'b01);
        chk("post_rst_done_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
